utlb_multi: RTL and testbench
=============================

# utlb_multi

Parametrised, fully associative instruction micro-TLB with ENTRIES slots sitting between the fetch stage and the shared main TLB search port. Hits translate in the same cycle. Misses run a one-cycle lookup on the main TLB, fill a FIFO-selected victim slot, and hold the result until fetch consumes it. It adds global-page matching, multi-entry replacement, flush-restart and hit/miss performance counters.

## Interface
- ENTRIES, 4, number of slots; power of two, 2..8
- ASID_W, 8, ASID width
- PFN_W, 20, physical frame number width
- CNT_W, 32, performance counter width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  fetch has an address to translate
- req_use_tlb  in  1  address lies in a mapped segment
- req_va  in  32  virtual address
- cur_asid  in  ASID_W  current ASID (EntryHi)
- done  in  1  fetch consumed result (addr_ok or TLB exception)
- flush  in  1  TLB written (tlbwi/tlbwr); invalidate all slots
- s_vpn2  out  19  main-TLB search VPN2
- s_odd  out  1  main-TLB search odd-page bit
- s_asid  out  ASID_W  main-TLB search ASID
- s_found, s_g, s_v, s_d  in  1 each  main-TLB search result, combinational from s_* outputs
- s_index  in  log2(16)=4  matching main-TLB index
- s_pfn  in  PFN_W; s_c  in  3
- rsp_ready  out  1  translation result valid this cycle
- rsp_found, rsp_v, rsp_d  out  1 each
- rsp_pfn  out  PFN_W; rsp_c  out  3; rsp_index  out  4
- hit_cnt, miss_cnt  out  CNT_W each  performance counters

## Operation
- Slot fields: valid, vpn2, odd, asid, g, pfn, c, d, v, index.
- Match condition: valid & vpn2==req_va[31:13] & odd==req_va[12] & (g | asid==cur_asid). If several slots match, the lowest index wins.
- FSM states:
  - IDLE: if req_valid & req_use_tlb & !hit, latch va/asid and go to LOOKUP. Otherwise stay.
  - LOOKUP: drive s_* from latched values. Sample s_* into the result register. Go to WAIT.
  - WAIT: hold the result until done, then go to IDLE.
- Fill: in LOOKUP, if s_found, write to slot victim_ptr and increment victim_ptr modulo ENTRIES. If !s_found, the result is presented with rsp_found=0, no slot is written and victim_ptr is unchanged.
- rsp_ready = (IDLE & req_valid & (hit | !req_use_tlb)) | WAIT.
- rsp_* source:
  - IDLE hit: the matching slot.
  - IDLE with !req_use_tlb, and any cycle where rsp_ready=0: all zero.
  - WAIT: the result register.
- Stored slots always have found=1.
- Flush: clears all valid bits at the next edge.
  - flush in LOOKUP: suppresses the fill and returns to LOOKUP to re-query.
  - flush in WAIT without done: returns to LOOKUP and re-queries with the latched va.
  - flush together with done: goes to IDLE.
- Counters:
  - hit_cnt increments on every IDLE cycle with req_valid & req_use_tlb & hit.
  - miss_cnt increments on every IDLE to LOOKUP transition.
  - Both wrap modulo 2^CNT_W.
- Reset values:
  - State IDLE, all valid=0, victim_ptr=0, counters 0, result register 0.
  - s_* outputs 0.
  - rsp_ready reduces to req_valid & !req_use_tlb.

## Timing
- Hit latency: 0 cycles (combinational, same cycle as req).
- Miss latency: result valid 2 cycles after the request cycle (IDLE, LOOKUP, then WAIT with rsp_ready=1).
- The main TLB search is combinational and is sampled at the end of LOOKUP. s_* outputs equal the latched values in LOOKUP and WAIT, and 0 in IDLE.
- A slot filled in LOOKUP is hittable from the first IDLE cycle after WAIT.
- req_va must stay stable from the request until rsp_ready & done. The block does not re-check req_va in WAIT.
- reset overrides everything, including a pending fill.

## Structure
- Package utlb_pkg holds:
  - the state enum (IDLE=2'd0, LOOKUP=2'd1, WAIT=2'd2)
  - the slot record typedef
  - the VPN2 width constant (19) and TLB index width (4)
- Sub-module utlb_entry: one slot's storage plus its match compare, with write enable and flush. It is instantiated ENTRIES times via generate. The top level holds the FSM, victim pointer, priority mux, result register and counters.

## Test plan
- After reset, req_valid=1, req_use_tlb=0, va=0xBFC0_0000 -> rsp_ready=1 same cycle, rsp_found=0, s_vpn2=0, counters stay 0.
- Miss then hit: va=0x0040_2000, asid=5, main TLB returns found=1, pfn=0x12345, g=0 -> rsp_ready in cycle +2 with rsp_pfn=0x12345. Pulse done. The repeat request hits in the same cycle with rsp_pfn=0x12345; hit_cnt=1, miss_cnt=1.
- Replacement, ENTRIES=4: fill pages 0x0040_0000, 0x0040_2000, 0x0040_4000, 0x0040_6000, 0x0040_8000 -> the fifth overwrites slot 0. Re-request 0x0040_0000 -> miss, miss_cnt=6.
- ASID/global: slot with asid=5, g=0, request with cur_asid=6 -> miss. Slot refilled with g=1 -> cur_asid=6 hits.
- Flush: assert flush in WAIT without done -> returns to LOOKUP, all slots invalid, the re-query result is presented. Flush in LOOKUP -> no slot written, victim_ptr unchanged.
- Not found: s_found=0 -> WAIT presents rsp_found=0, no allocation. The same va requested again misses again and miss_cnt increments.

Source files
------------

// File: rtl/utlb_pkg.sv
// Shared types for the instruction micro-TLB: FSM states, slot record and widths.
package utlb_pkg;

  localparam int VPN2_W = 19;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WAIT   = 2'd2
  } state_t;

  // ASID and PFN widths are block parameters, so those fields live beside this record.
  typedef struct packed {
    logic              valid;
    logic [VPN2_W-1:0] vpn2;
    logic              odd;
    logic              g;
    logic [2:0]        c;
    logic              d;
    logic              v;
    logic [IDX_W-1:0]  index;
  } slot_t;

endpackage

// File: rtl/utlb_entry.sv
// One micro-TLB slot: storage plus its match compare; flush wins over a write.
module utlb_entry
  import utlb_pkg::*;
#(
  parameter int ASID_W = 8,
  parameter int PFN_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              we,
  input  slot_t             wr_slot,
  input  logic [ASID_W-1:0] wr_asid,
  input  logic [PFN_W-1:0]  wr_pfn,
  input  logic [VPN2_W-1:0] req_vpn2,
  input  logic              req_odd,
  input  logic [ASID_W-1:0] cur_asid,
  output logic              match,
  output slot_t             rd_slot,
  output logic [PFN_W-1:0]  rd_pfn
);

  slot_t             slot;
  logic [ASID_W-1:0] asid;
  logic [PFN_W-1:0]  pfn;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot <= '0;
      asid <= '0;
      pfn  <= '0;
    end else if (flush) begin
      slot.valid <= 1'b0;
    end else if (we) begin
      slot <= wr_slot;
      asid <= wr_asid;
      pfn  <= wr_pfn;
    end
  end

  assign match = slot.valid && (slot.vpn2 == req_vpn2) && (slot.odd == req_odd) &&
                 (slot.g || (asid == cur_asid));
  assign rd_slot = slot;
  assign rd_pfn  = pfn;

endmodule

// File: rtl/utlb_multi.sv
// Fully associative instruction micro-TLB: same-cycle hits, one-cycle main-TLB lookup
// on a miss with FIFO victim fill, result held until fetch signals done.
module utlb_multi
  import utlb_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int ASID_W  = 8,
  parameter int PFN_W   = 20,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_use_tlb,
  input  logic [31:0]       req_va,
  input  logic [ASID_W-1:0] cur_asid,
  input  logic              done,
  input  logic              flush,
  output logic [18:0]       s_vpn2,
  output logic              s_odd,
  output logic [ASID_W-1:0] s_asid,
  input  logic              s_found,
  input  logic              s_g,
  input  logic              s_v,
  input  logic              s_d,
  input  logic [3:0]        s_index,
  input  logic [PFN_W-1:0]  s_pfn,
  input  logic [2:0]        s_c,
  output logic              rsp_ready,
  output logic              rsp_found,
  output logic              rsp_v,
  output logic              rsp_d,
  output logic [PFN_W-1:0]  rsp_pfn,
  output logic [2:0]        rsp_c,
  output logic [3:0]        rsp_index,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int PTR_W = $clog2(ENTRIES);

  state_t            state, state_nxt;
  logic [VPN2_W-1:0] vpn2_q;
  logic              odd_q;
  logic [ASID_W-1:0] asid_q;
  logic [PTR_W-1:0]  victim_ptr;

  logic              res_found, res_v, res_d;
  logic [PFN_W-1:0]  res_pfn;
  logic [2:0]        res_c;
  logic [IDX_W-1:0]  res_index;

  logic [ENTRIES-1:0] match;
  slot_t              rd_slot [ENTRIES];
  logic [PFN_W-1:0]   rd_pfn  [ENTRIES];
  slot_t              hit_slot;
  logic [PFN_W-1:0]   hit_pfn;
  logic               hit, idle_hit;
  logic               miss_start, sample, fill_we;
  slot_t              fill_slot;

  assign fill_slot = '{valid: 1'b1, vpn2: vpn2_q, odd: odd_q, g: s_g,
                       c: s_c, d: s_d, v: s_v, index: s_index};

  for (genvar i = 0; i < ENTRIES; i++) begin : g_slot
    utlb_entry #(
      .ASID_W(ASID_W),
      .PFN_W (PFN_W)
    ) u_entry (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .we      (fill_we && (victim_ptr == PTR_W'(i))),
      .wr_slot (fill_slot),
      .wr_asid (asid_q),
      .wr_pfn  (s_pfn),
      .req_vpn2(req_va[31:13]),
      .req_odd (req_va[12]),
      .cur_asid(cur_asid),
      .match   (match[i]),
      .rd_slot (rd_slot[i]),
      .rd_pfn  (rd_pfn[i])
    );
  end

  // Scan from the top so the lowest matching slot is the last one assigned.
  always_comb begin
    hit_slot = '0;
    hit_pfn  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_slot = rd_slot[i];
        hit_pfn  = rd_pfn[i];
      end
    end
  end

  assign hit      = |match;
  assign idle_hit = (state == IDLE) && req_valid && req_use_tlb && hit;

  always_comb begin
    state_nxt  = state;
    miss_start = 1'b0;
    sample     = 1'b0;
    fill_we    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_use_tlb && !hit) begin
          state_nxt  = LOOKUP;
          miss_start = 1'b1;
        end
      end
      LOOKUP: begin
        // A flush here discards the answer and re-queries next cycle.
        if (!flush) begin
          state_nxt = WAIT;
          sample    = 1'b1;
          fill_we   = s_found;
        end
      end
      WAIT: begin
        if (done)       state_nxt = IDLE;
        else if (flush) state_nxt = LOOKUP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      vpn2_q     <= '0;
      odd_q      <= 1'b0;
      asid_q     <= '0;
      victim_ptr <= '0;
      res_found  <= 1'b0;
      res_v      <= 1'b0;
      res_d      <= 1'b0;
      res_pfn    <= '0;
      res_c      <= '0;
      res_index  <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (miss_start) begin
        vpn2_q   <= req_va[31:13];
        odd_q    <= req_va[12];
        asid_q   <= cur_asid;
        miss_cnt <= miss_cnt + CNT_W'(1);
      end
      if (idle_hit) hit_cnt <= hit_cnt + CNT_W'(1);
      if (sample) begin
        res_found <= s_found;
        res_v     <= s_v;
        res_d     <= s_d;
        res_pfn   <= s_pfn;
        res_c     <= s_c;
        res_index <= s_index;
      end
      if (fill_we) victim_ptr <= victim_ptr + PTR_W'(1);
    end
  end

  assign s_vpn2 = (state != IDLE) ? vpn2_q : '0;
  assign s_odd  = (state != IDLE) ? odd_q  : 1'b0;
  assign s_asid = (state != IDLE) ? asid_q : '0;

  assign rsp_ready = ((state == IDLE) && req_valid && (hit || !req_use_tlb)) || (state == WAIT);

  always_comb begin
    rsp_found = 1'b0;
    rsp_v     = 1'b0;
    rsp_d     = 1'b0;
    rsp_pfn   = '0;
    rsp_c     = '0;
    rsp_index = '0;
    if (idle_hit) begin
      rsp_found = 1'b1;
      rsp_v     = hit_slot.v;
      rsp_d     = hit_slot.d;
      rsp_pfn   = hit_pfn;
      rsp_c     = hit_slot.c;
      rsp_index = hit_slot.index;
    end else if (state == WAIT) begin
      rsp_found = res_found;
      rsp_v     = res_v;
      rsp_d     = res_d;
      rsp_pfn   = res_pfn;
      rsp_c     = res_c;
      rsp_index = res_index;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{req_va[11:0], hit_slot.valid, hit_slot.vpn2, hit_slot.odd, hit_slot.g};

endmodule

// File: tb/tb_utlb_multi.sv
// Bench for utlb_multi: directed scenarios plus random traffic against a transaction-level model.
module tb_utlb_multi;
  localparam int ENTRIES = 4;
  localparam int ASID_W  = 8;
  localparam int PFN_W   = 20;
  localparam int CNT_W   = 32;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_use_tlb, done, flush;
  logic [31:0] req_va;
  logic [7:0]  cur_asid;
  logic [18:0] s_vpn2;
  logic        s_odd;
  logic [7:0]  s_asid;
  logic        s_found, s_g, s_v, s_d;
  logic [3:0]  s_index;
  logic [19:0] s_pfn;
  logic [2:0]  s_c;
  logic        rsp_ready, rsp_found, rsp_v, rsp_d;
  logic [19:0] rsp_pfn;
  logic [2:0]  rsp_c;
  logic [3:0]  rsp_index;
  logic [31:0] hit_cnt, miss_cnt;

  utlb_multi #(.ENTRIES(ENTRIES), .ASID_W(ASID_W), .PFN_W(PFN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_use_tlb(req_use_tlb),
    .req_va(req_va), .cur_asid(cur_asid), .done(done), .flush(flush),
    .s_vpn2(s_vpn2), .s_odd(s_odd), .s_asid(s_asid), .s_found(s_found), .s_g(s_g),
    .s_v(s_v), .s_d(s_d), .s_index(s_index), .s_pfn(s_pfn), .s_c(s_c),
    .rsp_ready(rsp_ready), .rsp_found(rsp_found), .rsp_v(rsp_v), .rsp_d(rsp_d),
    .rsp_pfn(rsp_pfn), .rsp_c(rsp_c), .rsp_index(rsp_index),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    logic [18:0] vpn2;
    bit          odd;
    logic [7:0]  asid;
    bit          g;
    logic [19:0] pfn;
    logic [2:0]  c;
    bit          d;
    bit          v;
    logic [3:0]  idx;
  } ent_t;

  ent_t mt [16];
  ent_t ref_slot [ENTRIES];
  int   ref_ptr, exp_hit, exp_miss;
  int   mt_gen = 0;
  int   checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int mt_find(logic [18:0] vpn2, logic odd, logic [7:0] asid);
    for (int i = 0; i < 16; i++)
      if (mt[i].valid && mt[i].vpn2 == vpn2 && mt[i].odd == odd && (mt[i].g || mt[i].asid == asid))
        return i;
    return -1;
  endfunction

  function automatic int ref_find(logic [31:0] va, logic [7:0] asid);
    for (int i = 0; i < ENTRIES; i++)
      if (ref_slot[i].valid && ref_slot[i].vpn2 == va[31:13] && ref_slot[i].odd == va[12] &&
          (ref_slot[i].g || ref_slot[i].asid == asid))
        return i;
    return -1;
  endfunction

  // Main TLB search port: combinational answer from the s_* outputs.
  always @(s_vpn2, s_odd, s_asid, mt_gen) begin
    int m;
    m = mt_find(s_vpn2, s_odd, s_asid);
    s_found = (m >= 0);
    s_g = 0; s_v = 0; s_d = 0; s_index = 0; s_pfn = 0; s_c = 0;
    if (m >= 0) begin
      s_g = mt[m].g; s_v = mt[m].v; s_d = mt[m].d;
      s_index = mt[m].idx; s_pfn = mt[m].pfn; s_c = mt[m].c;
    end
  end

  task automatic mt_set(input int i, input logic [31:0] va, input logic [7:0] asid,
                        input bit g, input logic [19:0] pfn);
    mt[i].valid = 1; mt[i].vpn2 = va[31:13]; mt[i].odd = va[12]; mt[i].asid = asid;
    mt[i].g = g; mt[i].pfn = pfn; mt[i].c = 3'(i % 8); mt[i].d = i[0]; mt[i].v = (i % 3) != 0;
    mt[i].idx = 4'(i);
    mt_gen++;
  endtask

  task automatic ref_clear();
    for (int i = 0; i < ENTRIES; i++) ref_slot[i].valid = 0;
  endtask

  task automatic ref_fill(input int m, input logic [7:0] asid);
    ref_slot[ref_ptr] = mt[m];
    ref_slot[ref_ptr].asid = asid;
    ref_slot[ref_ptr].valid = 1;
    ref_ptr = (ref_ptr + 1) % ENTRIES;
  endtask

  // Called at posedge+1 of the WAIT cycle; checks the held result, fills the model, consumes.
  task automatic wait_and_finish(input string tag, input logic [31:0] va, input logic [7:0] asid);
    int m;
    m = mt_find(va[31:13], va[12], asid);
    @(negedge clk);
    check({tag, "_wait_rdy"}, rsp_ready, 1);
    check({tag, "_wait_found"}, rsp_found, m >= 0);
    if (m >= 0) begin
      check({tag, "_wait_pfn"}, rsp_pfn, mt[m].pfn);
      check({tag, "_wait_attr"}, {rsp_c, rsp_d, rsp_v, rsp_index},
            {mt[m].c, mt[m].d, mt[m].v, mt[m].idx});
      ref_fill(m, asid);
    end else begin
      check({tag, "_nf_pfn"}, rsp_pfn, 0);
    end
    done = 1;
    @(posedge clk); #1;
    req_valid = 0; done = 0;
    @(negedge clk);
    check("hit_cnt", hit_cnt, exp_hit);
    check("miss_cnt", miss_cnt, exp_miss);
    check("idle_rdy", rsp_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic xact(input logic [31:0] va, input logic [7:0] asid, input bit use_tlb);
    int h;
    req_valid = 1; req_use_tlb = use_tlb; req_va = va; cur_asid = asid; done = 0;
    h = ref_find(va, asid);
    @(negedge clk);
    if (!use_tlb) begin
      check("bypass_rdy", rsp_ready, 1);
      check("bypass_found", rsp_found, 0);
      check("bypass_pfn", rsp_pfn, 0);
    end else if (h >= 0) begin
      exp_hit++;
      check("hit_rdy", rsp_ready, 1);
      check("hit_found", rsp_found, 1);
      check("hit_pfn", rsp_pfn, ref_slot[h].pfn);
      check("hit_attr", {rsp_c, rsp_d, rsp_v, rsp_index},
            {ref_slot[h].c, ref_slot[h].d, ref_slot[h].v, ref_slot[h].idx});
    end else begin
      exp_miss++;
      check("miss_rdy0", rsp_ready, 0);
      check("idle_svpn2", s_vpn2, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("lookup_rdy", rsp_ready, 0);
      check("lookup_s", {s_vpn2, s_odd, s_asid}, {va[31:12], asid});
      @(posedge clk); #1;
      wait_and_finish("miss", va, asid);
      return;
    end
    done = 1;
    @(posedge clk); #1;
    req_valid = 0; done = 0;
    @(negedge clk);
    check("hit_cnt", hit_cnt, exp_hit);
    check("miss_cnt", miss_cnt, exp_miss);
    check("idle_pfn0", rsp_pfn, 0);
    @(posedge clk); #1;
  endtask

  // Request va (must miss); flush in WAIT, then main TLB changes so the re-query is visible.
  task automatic flush_in_wait(input logic [31:0] va, input logic [7:0] asid, input logic [19:0] newpfn);
    int m;
    req_valid = 1; req_use_tlb = 1; req_va = va; cur_asid = asid; done = 0;
    exp_miss++;
    @(posedge clk); #1;
    m = mt_find(va[31:13], va[12], asid);
    if (m >= 0) ref_fill(m, asid);
    @(posedge clk); #1;
    @(negedge clk);
    check("fw_wait_rdy", rsp_ready, 1);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    ref_clear();
    if (m >= 0) begin mt[m].pfn = newpfn; mt_gen++; end
    @(negedge clk);
    check("fw_relookup_rdy", rsp_ready, 0);
    check("fw_relookup_s", s_vpn2, va[31:13]);
    @(posedge clk); #1;
    wait_and_finish("fw", va, asid);
  endtask

  task automatic flush_in_lookup(input logic [31:0] va, input logic [7:0] asid);
    req_valid = 1; req_use_tlb = 1; req_va = va; cur_asid = asid; done = 0;
    exp_miss++;
    @(posedge clk); #1;
    flush = 1;
    @(negedge clk);
    check("fl_lookup_rdy", rsp_ready, 0);
    @(posedge clk); #1;
    flush = 0;
    ref_clear();
    @(negedge clk);
    check("fl_relookup_rdy", rsp_ready, 0);
    check("fl_relookup_s", s_vpn2, va[31:13]);
    @(posedge clk); #1;
    wait_and_finish("fl", va, asid);
  endtask

  task automatic idle_flush();
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    ref_clear();
  endtask

  initial begin
    reset = 1; req_valid = 0; req_use_tlb = 0; req_va = 0; cur_asid = 0; done = 0; flush = 0;
    for (int i = 0; i < 16; i++) mt[i].valid = 0;
    mt_gen++;
    ref_clear(); ref_ptr = 0; exp_hit = 0; exp_miss = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_rdy", rsp_ready, 0);
    check("rst_s", {s_vpn2, s_odd, s_asid}, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    @(posedge clk); #1;

    xact(32'hBFC0_0000, 8'd0, 0);

    mt_set(0, 32'h0040_2000, 8'd5, 0, 20'h12345);
    xact(32'h0040_2000, 8'd5, 1);
    xact(32'h0040_2000, 8'd5, 1);
    check("plan_hit_cnt", hit_cnt, 1);
    check("plan_miss_cnt", miss_cnt, 1);

    mt_set(1, 32'h0040_0000, 8'd5, 0, 20'h0A001);
    mt_set(2, 32'h0040_4000, 8'd5, 0, 20'h0A002);
    mt_set(3, 32'h0040_6000, 8'd5, 0, 20'h0A003);
    mt_set(4, 32'h0040_8000, 8'd5, 0, 20'h0A004);
    xact(32'h0040_0000, 8'd5, 1);
    xact(32'h0040_4000, 8'd5, 1);
    xact(32'h0040_6000, 8'd5, 1);
    xact(32'h0040_8000, 8'd5, 1);
    xact(32'h0040_2000, 8'd5, 1);
    xact(32'h0040_0000, 8'd5, 1);
    xact(32'h0040_6000, 8'd5, 1);

    mt_set(5, 32'h0041_0000, 8'd5, 0, 20'hBEEF1);
    xact(32'h0041_0000, 8'd5, 1);
    xact(32'h0041_0000, 8'd6, 1);
    mt_set(5, 32'h0041_0000, 8'd5, 1, 20'hBEEF2);
    xact(32'h0041_0000, 8'd6, 1);
    xact(32'h0041_0000, 8'd6, 1);
    xact(32'h0041_0000, 8'd9, 1);

    xact(32'h0050_0000, 8'd5, 1);
    xact(32'h0050_0000, 8'd5, 1);

    mt_set(6, 32'h0042_0000, 8'd5, 0, 20'h11111);
    flush_in_wait(32'h0042_0000, 8'd5, 20'h22222);
    xact(32'h0040_8000, 8'd5, 1);
    xact(32'h0042_0000, 8'd5, 1);

    mt_set(7, 32'h0043_1000, 8'd5, 0, 20'h33333);
    flush_in_lookup(32'h0043_1000, 8'd5);
    xact(32'h0043_1000, 8'd5, 1);
    xact(32'h0042_0000, 8'd5, 1);

    for (int j = 0; j < 8; j++)
      mt_set(8 + j, 32'h0060_0000 + 32'(j) * 32'h1000, ($urandom % 2) ? 8'd5 : 8'd6,
             ($urandom % 3) == 0, 20'($urandom));
    idle_flush();
    for (int n = 0; n < 300; n++) begin
      logic [31:0] va;
      va = 32'h0060_0000 + 32'($urandom % 10) * 32'h1000;
      if (($urandom % 16) == 0) idle_flush();
      xact(va, ($urandom % 2) ? 8'd5 : 8'd6, ($urandom % 8) != 0);
    end

    req_valid = 1; req_use_tlb = 1; req_va = 32'h0070_0000; cur_asid = 8'd5;
    mt_set(8, 32'h0070_0000, 8'd5, 1, 20'h44444);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; req_valid = 0;
    ref_clear(); ref_ptr = 0; exp_hit = 0; exp_miss = 0;
    @(negedge clk);
    check("rst2_hit_cnt", hit_cnt, 0);
    check("rst2_miss_cnt", miss_cnt, 0);
    check("rst2_s", s_vpn2, 0);
    @(posedge clk); #1;
    xact(32'h0070_0000, 8'd5, 1);
    xact(32'h0070_0000, 8'd6, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
